// File: rtl/ps2_key_tracker_pkg.sv
// rtl/ps2_key_tracker_pkg.sv - shared constants, state and event types for the PS/2 key tracker
package ps2_key_tracker_pkg;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam int         PAUSE_SKIP = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } frame_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic       rep;
        logic [7:0] code;
    } key_evt_t;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return par == ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - synchroniser, glitch filter and falling-edge strobe for one PS/2 line
module ps2_line_filter #(
    parameter int FILTER_LEN = 8,
    parameter bit EDGE_EN    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic line_out,
    output logic fall
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // two-flop synchroniser; idle PS/2 lines are high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], line_in};
    end

    // follow the synchronised level only after it has differed for FILTER_LEN cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_out <= 1'b1;
            cnt      <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (sync[1] == line_out) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
                line_out <= sync[1];
                cnt      <= '0;
                fall     <= EDGE_EN && line_out;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 frame receiver, prefix decoder and held-key tracker
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter int                      FILTER_LEN  = 8,
    parameter int                      TIMEOUT_CYC = 100000,
    parameter int                      NUM_KEYS    = 12,
    parameter logic [NUM_KEYS*9-1:0]   KEY_CODES   = '0,
    parameter int                      ERR_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic                evt_valid,
    output logic [7:0]          evt_code,
    output logic                evt_ext,
    output logic                evt_break,
    output logic                evt_repeat,
    output logic [NUM_KEYS-1:0] key_down,
    output logic                frame_err,
    output logic [ERR_W-1:0]    err_count
);

    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic              strobe;
    logic              data_level;
    logic              clk_level_unused;
    logic              data_fall_unused;
    frame_state_t      state, state_nxt;
    logic [9:0]        shreg;
    logic [3:0]        bit_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              byte_good, byte_bad;
    logic              ext_flag, brk_flag;
    logic [2:0]        pause_cnt;
    logic [NUM_KEYS-1:0] match;
    key_evt_t          evt_q;
    logic [7:0]        rx_byte;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN), .EDGE_EN(1'b1)) u_clk_filter (
        .clk(clk), .rst_n(rst_n), .line_in(ps2_clk),
        .line_out(clk_level_unused), .fall(strobe)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN), .EDGE_EN(1'b0)) u_data_filter (
        .clk(clk), .rst_n(rst_n), .line_in(ps2_data),
        .line_out(data_level), .fall(data_fall_unused)
    );

    assign rx_byte = shreg[7:0];

    // frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // frame sequencing; a strobe in the same cycle as the timeout keeps the frame alive
    always_comb begin
        state_nxt = state;
        byte_good = 1'b0;
        byte_bad  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (strobe && !data_level) state_nxt = ST_RECV;
            end
            ST_RECV: begin
                if (strobe) begin
                    if (bit_cnt == 4'd9) state_nxt = ST_CHECK;
                end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    state_nxt = ST_IDLE;
                    byte_bad  = 1'b1;
                end
            end
            ST_CHECK: begin
                state_nxt = ST_IDLE;
                if (odd_parity_ok(rx_byte, shreg[8]) && shreg[9]) byte_good = 1'b1;
                else                                                byte_bad  = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // LSB-first shifter, bit counter and inter-strobe timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            to_cnt  <= '0;
        end else if (state != ST_RECV) begin
            bit_cnt <= '0;
            to_cnt  <= '0;
        end else if (strobe) begin
            shreg   <= {data_level, shreg[9:1]};
            bit_cnt <= bit_cnt + 1'b1;
            to_cnt  <= '0;
        end else begin
            to_cnt  <= to_cnt + 1'b1;
        end
    end

    // compare the pending {ext, code} against every tracked key at once
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            match[i] = ({ext_flag, rx_byte} == KEY_CODES[9*i +: 9]);
        end
    end

    // prefix decode, event register, held-key state and error counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
            pause_cnt <= '0;
            evt_valid <= 1'b0;
            evt_q     <= '0;
            key_down  <= '0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            evt_valid <= 1'b0;
            frame_err <= 1'b0;
            if (byte_bad) begin
                frame_err <= 1'b1;
                if (err_count != '1) err_count <= err_count + 1'b1;
                ext_flag  <= 1'b0;
                brk_flag  <= 1'b0;
                pause_cnt <= '0;
            end else if (byte_good) begin
                if (pause_cnt != '0) begin
                    pause_cnt <= pause_cnt - 1'b1;
                end else if (rx_byte == PS2_BREAK) begin
                    brk_flag <= 1'b1;
                end else if (rx_byte == PS2_EXT) begin
                    ext_flag <= 1'b1;
                end else if (rx_byte == PS2_PAUSE) begin
                    pause_cnt <= 3'(PAUSE_SKIP);
                end else begin
                    evt_valid <= 1'b1;
                    evt_q     <= '{ext:  ext_flag,
                                   brk:  brk_flag,
                                   rep:  !brk_flag && |(match & key_down),
                                   code: rx_byte};
                    key_down  <= brk_flag ? (key_down & ~match) : (key_down | match);
                    ext_flag  <= 1'b0;
                    brk_flag  <= 1'b0;
                end
            end
        end
    end

    assign evt_code   = evt_q.code;
    assign evt_ext    = evt_q.ext;
    assign evt_break  = evt_q.brk;
    assign evt_repeat = evt_q.rep;

endmodule
